// File: rtl/amem_arb.sv
// amem_arb: arbitrates the single-port A-memory SRAM between the CPU A-control
// path and the console spy port.
// The CPU has priority and passes straight through to the SRAM in the same cycle.
// Spy accesses fill idle A-memory cycles. A spy that has been denied too long
// forces one stolen cycle through a registered cpu_stall.
//
// Ports:
//   clk, reset                         clock, async active-high reset
//   cpu_arp/cpu_awp/cpu_aadr/cpu_wdata CPU A-memory strobes, address, write data
//   spy_req/spy_wr/spy_adr/spy_wdata   spy request (level) and access, latched at accept
//   spy_ack/spy_rdata                  one-cycle completion pulse, read data
//   cpu_stall                          registered one-cycle hold-off to the CPU
//   conflict                           sticky: CPU strobed while stalled
//   mem_adr/mem_wdata/mem_we/mem_re    SRAM request
//   mem_rdata                          SRAM read data, one cycle after mem_re
`timescale 1ns/1ps
module amem_arb #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAXWAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_arp,
    input  logic          cpu_awp,
    input  logic [AW-1:0] cpu_aadr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          spy_req,
    input  logic          spy_wr,
    input  logic [AW-1:0] spy_adr,
    input  logic [DW-1:0] spy_wdata,
    output logic          spy_ack,
    output logic [DW-1:0] spy_rdata,
    output logic          cpu_stall,
    output logic          conflict,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_spy_wr;
    logic [AW-1:0]   r_spy_adr;
    logic [DW-1:0]   r_spy_wdata;
    logic [CW-1:0]   r_cnt;
    logic            r_spy_ack;
    logic [DW-1:0]   r_spy_rdata;
    logic            r_cpu_stall;
    logic            r_conflict;

    logic            w_cpu_strobe;
    logic            w_spy_drive;

    assign w_cpu_strobe = cpu_arp | cpu_awp;
    // A stall cycle always belongs to the spy; otherwise the spy only gets
    // ISSUE cycles the CPU leaves free.
    assign w_spy_drive  = r_cpu_stall | ((r_state == S_ISSUE) & ~w_cpu_strobe);

    assign spy_ack   = r_spy_ack;
    assign spy_rdata = r_spy_rdata;
    assign cpu_stall = r_cpu_stall;
    assign conflict  = r_conflict;

    // SRAM request mux; idle cycles keep the CPU address on the bus.
    always_comb begin
        mem_adr   = cpu_aadr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (w_spy_drive) begin
            mem_adr   = r_spy_adr;
            mem_wdata = r_spy_wdata;
            mem_we    = r_spy_wr;
            mem_re    = ~r_spy_wr;
        end else if (w_cpu_strobe) begin
            mem_we    = cpu_awp;
            mem_re    = cpu_arp & ~cpu_awp;
        end
    end

    // Spy access sequencer with starvation counter and stall request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_spy_wr    <= 1'b0;
            r_spy_adr   <= '0;
            r_spy_wdata <= '0;
            r_cnt       <= '0;
            r_spy_ack   <= 1'b0;
            r_spy_rdata <= '0;
            r_cpu_stall <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_spy_ack <= 1'b0;
            if (r_cpu_stall && w_cpu_strobe) begin
                r_conflict <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (spy_req && !r_spy_ack) begin
                        r_spy_wr    <= spy_wr;
                        r_spy_adr   <= spy_adr;
                        r_spy_wdata <= spy_wdata;
                        r_cnt       <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_spy_drive) begin
                        r_cpu_stall <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_DONE;
                    end else if (r_cnt == CW'(MAXWAIT)) begin
                        // Counter parks at MAXWAIT; the stall guarantees the next grant.
                        r_cpu_stall <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (!r_spy_wr) begin
                        r_spy_rdata <= mem_rdata;
                    end
                    r_spy_ack <= 1'b1;
                    r_state   <= S_ACK;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
